// File: rtl/vga_stream_ctrl.sv
// VGA timing generator with frame-synchronous source mux, colour-bar
// fallback and a matched output pipeline for pixel and sync.
module vga_stream_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CBITS    = 2,
  parameter int   NUM_SRC  = 4,
  parameter int   SEL_W    = 2,
  parameter int   PIPE     = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_SRC*3*CBITS-1:0] src_data,
  input  logic [SEL_W-1:0]           src_sel,
  output logic [9:0]                 x,
  output logic [9:0]                 y,
  output logic                       hs,
  output logic                       vs,
  output logic [3*CBITS-1:0]         rgb,
  output logic                       active,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [15:0]                frame_count
);

  localparam int PW = 3 * CBITS;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST = 10'(HT - 1);
  localparam logic [9:0] Y_LAST = 10'(VT - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_B   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_B   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic [PW-1:0] rgb;
  } pix_t;

  localparam pix_t IDLE = pix_t'{
    hs:  ~SYNC_POL,
    vs:  ~SYNC_POL,
    act: 1'b0,
    rgb: '0
  };

  logic [SEL_W-1:0] sel_q;
  logic             x_end;
  logic             y_end;
  logic             act0;
  logic [2:0]       bar;
  logic [PW-1:0]    pix0;
  pix_t             st0;
  pix_t             pipe_q [PIPE];

  assign x_end = (x == X_LAST);
  assign y_end = (y == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  // Source choice only moves on the last tick of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= '0;
      frame_count <= '0;
    end else if (enable && x_end && y_end) begin
      sel_q       <= src_sel;
      frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    bar  = x[9:7];
    pix0 = {{CBITS{bar[2]}}, {CBITS{bar[1]}}, {CBITS{bar[0]}}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == SEL_W'(i)) pix0 = src_data[i*PW +: PW];
    end
  end

  assign act0 = (x < HA) && (y < VA);

  always_comb begin
    st0     = IDLE;
    st0.act = act0;
    st0.hs  = (x >= HS_B && x <= HS_E) ? SYNC_POL : ~SYNC_POL;
    st0.vs  = (y >= VS_B && y <= VS_E) ? SYNC_POL : ~SYNC_POL;
    st0.rgb = act0 ? pix0 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= IDLE;
    end else if (enable) begin
      pipe_q[0] <= st0;
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign hs     = pipe_q[PIPE-1].hs;
  assign vs     = pipe_q[PIPE-1].vs;
  assign active = pipe_q[PIPE-1].act;
  assign rgb    = pipe_q[PIPE-1].rgb;

  assign line_start  = enable && (x == '0);
  assign frame_start = enable && (x == '0) && (y == '0);

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Directed bench for vga_stream_ctrl: full-width lines, a 7-line frame
// so whole frames fit a short run, three sources plus colour bars.
module tb_vga_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [17:0] src_data;
  logic [1:0]  src_sel = 2'd0;
  logic [9:0]  x, y;
  logic        hs, vs, active, line_start, frame_start;
  logic [5:0]  rgb;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;
  int n = 0;

  vga_stream_ctrl #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .NUM_SRC(3), .SEL_W(2), .PIPE(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_data(src_data), .src_sel(src_sel),
    .x(x), .y(y), .hs(hs), .vs(vs), .rgb(rgb),
    .active(active), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic e);
    enable = e;
    @(posedge clk);
    if (e) n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (x !== 10'd0 || y !== 10'd0) begin
      fails++; $display("FAIL rst_xy got %0d,%0d want 0,0", x, y); end
    tests++; if ({hs, vs, active, rgb} !== 9'b110_000000) begin
      fails++; $display("FAIL rst_out got hs%b vs%b act%b rgb%h", hs, vs, active, rgb); end
    tests++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin
      fails++; $display("FAIL rst_strobe_off got %b%b want 00", line_start, frame_start); end
    enable = 1'b1; #1;
    tests++; if (frame_start !== 1'b1) begin
      fails++; $display("FAIL first_frame_start got %b want 1", frame_start); end
    while (n < 300) tick(1'b1);
    tests++; if (x !== 10'd300 || rgb !== 6'h3F || active !== 1'b1) begin
      fails++; $display("FAIL pre_rst got x%0d rgb%h act%b want 300 3f 1", x, rgb, active); end
    #2 rst = 1'b1;
    #1;
    tests++; if (x !== 10'd0 || y !== 10'd0 || frame_count !== 16'd0) begin
      fails++; $display("FAIL async_rst got x%0d y%0d fc%0d", x, y, frame_count); end
    tests++; if ({hs, vs, active, rgb} !== 9'b110_000000) begin
      fails++; $display("FAIL async_rst_out got hs%b vs%b act%b rgb%h", hs, vs, active, rgb); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    enable = 1'b1; #1;
    tests++; if (frame_start !== 1'b1) begin
      fails++; $display("FAIL post_rst_frame_start got %b want 1", frame_start); end
  endtask

  task automatic test_hsync();
    int f1, f2, low, ls1, ls2;
    logic prev;
    f1 = -1; f2 = -1; low = 0; ls1 = -1; ls2 = -1; prev = 1'b1;
    do_reset();
    for (int i = 0; i < 1700; i++) begin
      enable = 1'b1; #1;
      if (prev && !hs) begin
        if (f1 < 0) f1 = n; else if (f2 < 0) f2 = n;
      end
      if (!hs && n < 800) low++;
      if (line_start) begin
        if (ls1 < 0) ls1 = n; else if (ls2 < 0) ls2 = n;
      end
      prev = hs;
      tick(1'b1);
    end
    tests++; if (f1 !== 658) begin
      fails++; $display("FAIL hs_first_fall got %0d want 658", f1); end
    tests++; if (low !== 96) begin
      fails++; $display("FAIL hs_width got %0d want 96", low); end
    tests++; if (f2 - f1 !== 800) begin
      fails++; $display("FAIL hs_period got %0d want 800", f2 - f1); end
    tests++; if (ls1 !== 0 || ls2 !== 800) begin
      fails++; $display("FAIL line_start got %0d,%0d want 0,800", ls1, ls2); end
  endtask

  task automatic test_frame();
    int f1, low, fs1, fs2;
    logic prev;
    f1 = -1; low = 0; fs1 = -1; fs2 = -1; prev = 1'b1;
    do_reset();
    for (int i = 0; i < 16800; i++) begin
      enable = 1'b1; #1;
      if (prev && !vs && f1 < 0) f1 = n;
      if (!vs && n < 5600) low++;
      if (frame_start) begin
        if (fs1 < 0) fs1 = n; else if (fs2 < 0) fs2 = n;
      end
      if (n == 5599) begin
        tests++; if (frame_count !== 16'd0) begin
          fails++; $display("FAIL fc_before_end got %0d want 0", frame_count); end
      end
      if (n == 5600) begin
        tests++; if (frame_count !== 16'd1) begin
          fails++; $display("FAIL fc_after_end got %0d want 1", frame_count); end
      end
      prev = vs;
      tick(1'b1);
    end
    tests++; if (f1 !== 4002) begin
      fails++; $display("FAIL vs_first_fall got %0d want 4002", f1); end
    tests++; if (low !== 800) begin
      fails++; $display("FAIL vs_width got %0d want 800", low); end
    tests++; if (fs1 !== 0 || fs2 !== 5600) begin
      fails++; $display("FAIL frame_start got %0d,%0d want 0,5600", fs1, fs2); end
    tests++; if (frame_count !== 16'd3) begin
      fails++; $display("FAIL frame_count got %0d want 3", frame_count); end
  endtask

  task automatic test_enable_gating();
    int f1, f2, bad;
    logic prev, e;
    f1 = -1; f2 = -1; bad = 0; prev = 1'b1;
    do_reset();
    #1;
    tests++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin
      fails++; $display("FAIL gate_idle_strobe got %b%b want 00", line_start, frame_start); end
    for (int c = 0; c < 3000; c++) begin
      e = (c % 2 == 0);
      enable = e; #1;
      if (prev && !hs) begin
        if (f1 < 0) f1 = c; else if (f2 < 0) f2 = c;
      end
      if (!e && (line_start || frame_start)) bad++;
      prev = hs;
      tick(e);
    end
    tests++; if (f2 - f1 !== 1600) begin
      fails++; $display("FAIL gate_hs_period got %0d want 1600", f2 - f1); end
    tests++; if (bad !== 0) begin
      fails++; $display("FAIL gate_strobe got %0d pulses want 0", bad); end
    tests++; if (x !== 10'd700 || y !== 10'd1) begin
      fails++; $display("FAIL gate_xy got %0d,%0d want 700,1", x, y); end
  endtask

  task automatic test_source_switch();
    int tn [6] = '{1702, 3041, 3042, 5601, 5602, 6241};
    logic [5:0] te [6] = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h15, 6'h15};
    src_sel = 2'd0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      while (n < tn[k]) begin
        if (n == 800) src_sel = 2'd1;
        tick(1'b1);
      end
      tests++; if (rgb !== te[k]) begin
        fails++; $display("FAIL src_switch n%0d got %h want %h", n, rgb, te[k]); end
    end
  endtask

  task automatic test_colour_bars();
    int tx [11] = '{0, 127, 128, 255, 256, 383, 384, 511, 512, 639, 640};
    logic [5:0] te [11] = '{6'h00, 6'h00, 6'h03, 6'h03, 6'h0C, 6'h0C,
                            6'h0F, 6'h0F, 6'h30, 6'h30, 6'h00};
    src_sel = 2'd3;
    do_reset();
    while (n < 102) tick(1'b1);
    tests++; if (rgb !== 6'h3F) begin
      fails++; $display("FAIL bars_midframe got %h want 3f", rgb); end
    for (int k = 0; k < 11; k++) begin
      while (n < 5602 + tx[k]) tick(1'b1);
      tests++; if (rgb !== te[k]) begin
        fails++; $display("FAIL bars x%0d got %h want %h", tx[k], rgb, te[k]); end
    end
  endtask

  initial begin
    src_data = {6'h2A, 6'h15, 6'h3F};
    test_reset();
    test_hsync();
    test_frame();
    test_enable_gating();
    test_source_switch();
    test_colour_bars();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
